// File: rtl/efuse_wb_ctrl.sv
// efuse_wb_ctrl: Wishbone classic slave for a one-time-programmable eFuse macro.
// Reads hold the macro read strobe for a fixed number of cycles and return the word.
// Writes walk the data bits LSB first and issue one timed blow pulse per 1-bit,
// followed by a recovery gap. Programming is interlocked by prog_en_i sampled at request time.
// A started blow pulse always runs to full length unless wb_rst_i is asserted.
module efuse_wb_ctrl #(
   parameter int AW          = 12,
   parameter int DW          = 8,
   parameter int RD_CYCLES   = 4,
   parameter int PROG_CYCLES = 100,
   parameter int GAP_CYCLES  = 2,
   localparam int IW         = (DW > 1) ? $clog2(DW) : 1
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic          wb_we_i,
   input  logic          wb_sel_i,
   input  logic [AW-1:0] wb_adr_i,
   input  logic [DW-1:0] wb_dat_i,
   output logic [DW-1:0] wb_dat_o,
   output logic          wb_ack_o,
   input  logic          prog_en_i,
   output logic          busy_o,
   output logic          efuse_cs_o,
   output logic          efuse_rd_o,
   output logic          efuse_prog_o,
   output logic [AW-1:0] efuse_addr_o,
   output logic [IW-1:0] efuse_bit_o,
   input  logic [DW-1:0] efuse_q_i
);

   // One shared down-counter times READ, PROG and GAP; size it for the longest of the three.
   localparam int MAX_RP = (RD_CYCLES > PROG_CYCLES) ? RD_CYCLES : PROG_CYCLES;
   localparam int MAX_C  = (MAX_RP > GAP_CYCLES) ? MAX_RP : GAP_CYCLES;
   localparam int CW     = $clog2(MAX_C + 1);

   localparam logic [CW-1:0] RD_LOAD   = CW'(RD_CYCLES - 1);
   localparam logic [CW-1:0] PROG_LOAD = CW'(PROG_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(DW - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      SCAN = 3'd2,
      PROG = 3'd3,
      GAP  = 3'd4,
      ACK  = 3'd5
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg,   cnt_next;
   logic [IW-1:0] idx_reg,   idx_next;
   logic [AW-1:0] addr_reg,  addr_next;
   logic [DW-1:0] data_reg,  data_next;
   logic [DW-1:0] rdat_reg,  rdat_next;
   logic          abort_reg, abort_next;

   // State and datapath registers; reset returns everything to zero/IDLE, cutting any pulse.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         addr_reg  <= '0;
         data_reg  <= '0;
         rdat_reg  <= '0;
         abort_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         addr_reg  <= addr_next;
         data_reg  <= data_next;
         rdat_reg  <= rdat_next;
         abort_reg <= abort_next;
      end
   end

   // Next-state logic: request decode, read timing, bit scan, pulse/gap timing and aborts.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      addr_next  = addr_reg;
      data_next  = data_reg;
      rdat_next  = rdat_reg;
      abort_next = abort_reg;

      case (state_reg)
         IDLE: begin
            abort_next = 1'b0;
            if (wb_cyc_i && wb_stb_i) begin
               addr_next = wb_adr_i;
               data_next = wb_dat_i;
               idx_next  = '0;
               if (!wb_we_i) begin
                  state_next = READ;
                  cnt_next   = RD_LOAD;
               end else if (prog_en_i && wb_sel_i) begin
                  state_next = SCAN;
               end else begin
                  // Locked or unselected write: acknowledge without touching the macro.
                  state_next = ACK;
               end
            end
         end

         READ: begin
            if (!wb_cyc_i) begin
               state_next = IDLE;
            end else if (cnt_reg == '0) begin
               rdat_next  = efuse_q_i;
               state_next = ACK;
            end else begin
               cnt_next = cnt_reg - CW'(1);
            end
         end

         SCAN: begin
            if (!wb_cyc_i) begin
               state_next = IDLE;
            end else if (data_reg[idx_reg]) begin
               state_next = PROG;
               cnt_next   = PROG_LOAD;
            end else if (idx_reg == LAST_IDX) begin
               state_next = ACK;
            end else begin
               idx_next = idx_reg + IW'(1);
            end
         end

         PROG: begin
            // A dropped cycle is remembered but the pulse is never shortened by the bus.
            if (cnt_reg == '0) begin
               if (abort_reg || !wb_cyc_i) begin
                  state_next = IDLE;
               end else begin
                  state_next = GAP;
                  cnt_next   = GAP_LOAD;
               end
            end else begin
               cnt_next = cnt_reg - CW'(1);
               if (!wb_cyc_i) begin
                  abort_next = 1'b1;
               end
            end
         end

         GAP: begin
            if (!wb_cyc_i) begin
               state_next = IDLE;
            end else if (cnt_reg == '0) begin
               if (idx_reg == LAST_IDX) begin
                  state_next = ACK;
               end else begin
                  idx_next   = idx_reg + IW'(1);
                  state_next = SCAN;
               end
            end else begin
               cnt_next = cnt_reg - CW'(1);
            end
         end

         ACK: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign wb_dat_o     = rdat_reg;
   assign wb_ack_o     = (state_reg == ACK);
   assign busy_o       = (state_reg != IDLE);
   assign efuse_cs_o   = (state_reg == READ) || (state_reg == SCAN) ||
                         (state_reg == PROG) || (state_reg == GAP);
   assign efuse_rd_o   = (state_reg == READ);
   assign efuse_prog_o = (state_reg == PROG);
   assign efuse_addr_o = addr_reg;
   assign efuse_bit_o  = idx_reg;

endmodule
